// File: rtl/agc_alu.sv
// rtl/agc_alu.sv - ones'-complement ALU with iterative multiply/divide engines
//
// Purpose:
//   Arithmetic stage behind the control-pulse FSM. Single-cycle add, subtract
//   and mask; multi-cycle shift-add multiply (MP0) and restoring divide (DV0)
//   behind a start/busy/done handshake. MP1 and DV1 return the high product
//   word and the quotient that the preceding MP0/DV0 left behind.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   start   in   one-cycle request, sampled only in IDLE
//   alu_op  in   AD=0 SU=1 MASK=2 MP0=3 MP1=4 DV0=5 DV1=6 (7 returns zero)
//   x       in   operand X; dividend high word for DV0
//   y       in   operand Y; divisor for DV0
//   lp_in   in   dividend low word for DV0 (magnitude bits only)
//   result  out  registered result, held until the next accepted start
//   ovf     out  overflow flag of the last operation
//   busy    out  high whenever not IDLE
//   done    out  one-cycle completion pulse
module agc_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] lp_in,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int MW = WIDTH - 1;
  localparam int CW = $clog2(MW + 1);

  localparam logic [2:0] OP_AD   = 3'd0;
  localparam logic [2:0] OP_SU   = 3'd1;
  localparam logic [2:0] OP_MASK = 3'd2;
  localparam logic [2:0] OP_MP0  = 3'd3;
  localparam logic [2:0] OP_MP1  = 3'd4;
  localparam logic [2:0] OP_DV0  = 3'd5;
  localparam logic [2:0] OP_DV1  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // MUL: 2*MW-bit product accumulator.
  // DIV: {partial remainder, dividend low bits shifting out / quotient bits shifting in}.
  logic [2*MW-1:0]   acc_q, acc_d;
  // Multiplicand magnitude in MUL, divisor magnitude in DIV.
  logic [MW-1:0]     mc_q, mc_d;
  // Multiplier magnitude, consumed LSB first.
  logic [MW-1:0]     mp_q, mp_d;
  logic              sx_q, sx_d;
  logic              sy_q, sy_d;
  // Values left behind for MP1 / DV1.
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic              dv_ovf_q, dv_ovf_d;

  function automatic logic [MW-1:0] mag(input logic [WIDTH-1:0] w);
    return w[WIDTH-1] ? ~w[MW-1:0] : w[MW-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [MW-1:0] m);
    return neg ? {1'b1, ~m} : {1'b0, m};
  endfunction

  logic [MW-1:0]     mag_x;
  logic [MW-1:0]     mag_y;
  logic              unused_lp_sign;

  assign mag_x          = mag(x);
  assign mag_y          = mag(y);
  assign unused_lp_sign = lp_in[WIDTH-1];

  // Ones'-complement add: the carry out of the sign bit wraps into bit 0.
  logic [WIDTH-1:0]  add_b;
  logic [WIDTH:0]    add_raw;
  logic [WIDTH-1:0]  add_sum;
  logic              add_ovf;

  assign add_b   = (alu_op == OP_SU) ? ~y : y;
  assign add_raw = {1'b0, x} + {1'b0, add_b};
  assign add_sum = add_raw[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, add_raw[WIDTH]};
  assign add_ovf = (x[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != x[WIDTH-1]);

  // One shift-add multiply step. The extra sum bit is the carry that the
  // right shift brings back into the top of the accumulator.
  logic [MW:0]       mul_sum;
  logic [2*MW-1:0]   mul_next;
  logic              prod_neg;

  assign mul_sum  = {1'b0, acc_q[2*MW-1:MW]} + {1'b0, mc_q};
  assign mul_next = mp_q[0] ? {mul_sum, acc_q[MW-1:1]} : {1'b0, acc_q[2*MW-1:1]};
  assign prod_neg = (sx_q ^ sy_q) && (mul_next != '0);

  // One restoring-divide step: shift {remainder, low} left, trial-subtract.
  logic [MW:0]       div_shift;
  logic              div_ge;
  logic [MW-1:0]     div_sub;
  logic [MW-1:0]     div_rem;
  logic [MW-1:0]     div_quo;

  assign div_shift = acc_q[2*MW-1:MW-1];
  assign div_ge    = div_shift >= {1'b0, mc_q};
  assign div_sub   = div_shift[MW-1:0] - mc_q;
  assign div_rem   = div_ge ? div_sub : div_shift[MW-1:0];
  assign div_quo   = {acc_q[MW-2:0], div_ge};

  // The quotient only fits in MW bits when the high dividend word is
  // strictly smaller than the divisor.
  logic              dv_early_ovf;
  logic              last_iter;

  assign dv_early_ovf = (mag_y == '0) || (mag_x >= mag_y);
  assign last_iter    = (cnt_q == CW'(1));

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    hi_d     = hi_q;
    quo_d    = quo_q;
    dv_ovf_d = dv_ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sx_d    = x[WIDTH-1];
          sy_d    = y[WIDTH-1];
          state_d = ST_DONE;
          case (alu_op)
            OP_AD, OP_SU: begin
              result_d = add_sum;
              ovf_d    = add_ovf;
            end
            OP_MASK: begin
              result_d = x & y;
              ovf_d    = 1'b0;
            end
            OP_MP0: begin
              mc_d    = mag_x;
              mp_d    = mag_y;
              acc_d   = '0;
              cnt_d   = CW'(MW);
              state_d = ST_MUL;
            end
            OP_MP1: begin
              result_d = hi_q;
              ovf_d    = 1'b0;
            end
            OP_DV0: begin
              if (dv_early_ovf) begin
                result_d = x;
                ovf_d    = 1'b1;
                quo_d    = apply_sign(x[WIDTH-1] ^ y[WIDTH-1], '1);
                dv_ovf_d = 1'b1;
              end else begin
                acc_d   = {mag_x, lp_in[MW-1:0]};
                mc_d    = mag_y;
                cnt_d   = CW'(MW);
                state_d = ST_DIV;
              end
            end
            OP_DV1: begin
              result_d = quo_q;
              ovf_d    = dv_ovf_q;
            end
            default: begin
              result_d = '0;
              ovf_d    = 1'b0;
            end
          endcase
        end
      end

      ST_MUL: begin
        acc_d = mul_next;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (last_iter) begin
          result_d = apply_sign(prod_neg, mul_next[MW-1:0]);
          ovf_d    = 1'b0;
          hi_d     = apply_sign(prod_neg, mul_next[2*MW-1:MW]);
          state_d  = ST_DONE;
        end
      end

      ST_DIV: begin
        acc_d = {div_rem, div_quo};
        cnt_d = cnt_q - CW'(1);
        if (last_iter) begin
          // Zero magnitudes come out as +0 regardless of operand signs.
          result_d = apply_sign(sx_q && (div_rem != '0), div_rem);
          ovf_d    = 1'b0;
          quo_d    = apply_sign((sx_q ^ sy_q) && (div_quo != '0), div_quo);
          dv_ovf_d = 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      hi_q     <= '0;
      quo_q    <= '0;
      dv_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      hi_q     <= hi_d;
      quo_q    <= quo_d;
      dv_ovf_q <= dv_ovf_d;
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);

endmodule
